// File: rtl/instr_mem_fetch.sv
// instr_mem_fetch
//   Parametrised instruction memory for the fetch stage. After reset it
//   clears every word with a hardware sweep. It then accepts program
//   writes and serves fetches over a valid/ready handshake. A fetch
//   response appears one cycle after the request is accepted. Misaligned
//   or out-of-range fetches are flagged and return FAULT_INSTR.
//
// Ports
//   clk, reset_n            clock (rising edge), async active-low reset
//   init_done               clear sweep finished (state RUN)
//   prog_we/addr/data       program write port; accepted when prog_ready
//   prog_ready              write port open (RUN)
//   req_valid/addr/ready    fetch request handshake (byte address)
//   resp_valid/ready        fetch response handshake
//   resp_instr              fetched word, or FAULT_INSTR on a fault
//   resp_fault              00 ok, 01 misaligned, 10 out of range
module instr_mem_fetch #(
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned AW          = 32,
    parameter logic [31:0] CLEAR_VALUE = 32'h0000_0000,
    parameter logic [31:0] FAULT_INSTR = 32'h0000_0013
) (
    input  logic                     clk,
    input  logic                     reset_n,
    output logic                     init_done,
    input  logic                     prog_we,
    input  logic [$clog2(DEPTH)-1:0] prog_addr,
    input  logic [31:0]              prog_data,
    output logic                     prog_ready,
    input  logic                     req_valid,
    input  logic [AW-1:0]            req_addr,
    output logic                     req_ready,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [31:0]              resp_instr,
    output logic [1:0]               resp_fault
);

    localparam int unsigned IW = $clog2(DEPTH);

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          init_done_q, init_done_d;
    logic          prog_ready_q, prog_ready_d;
    logic          resp_valid_q, resp_valid_d;
    logic [31:0]   resp_instr_q, resp_instr_d;
    logic [1:0]    resp_fault_q, resp_fault_d;

    logic [31:0]   mem [DEPTH];

    logic          mem_we;
    logic [IW-1:0] mem_waddr;
    logic [31:0]   mem_wdata;

    logic [AW-3:0] word_addr;
    logic [AW-3:0] word_hi;
    logic          misaligned;
    logic          out_of_range;
    logic [1:0]    fault_code;
    logic [IW-1:0] rd_idx;
    logic          accept;
    logic          retire;

    // DEPTH is a power of two, so word_addr >= DEPTH exactly when any bit
    // above the index field is set. The full word address is examined, so
    // large addresses never alias onto valid words.
    assign word_addr    = req_addr[AW-1:2];
    assign word_hi      = word_addr >> IW;
    assign misaligned   = (req_addr[1:0] != 2'b00);
    assign out_of_range = |word_hi;
    assign rd_idx       = req_addr[IW+1:2];

    always_comb begin
        fault_code = 2'b00;
        if (misaligned) begin
            fault_code = 2'b01;
        end else if (out_of_range) begin
            fault_code = 2'b10;
        end
    end

    // A program write has priority, so a fetch waits out the write cycle.
    assign req_ready = (state_q == RUN) && !prog_we
                       && (!resp_valid_q || resp_ready);
    assign accept    = req_valid && req_ready;
    assign retire    = resp_valid_q && resp_ready;

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = idx_q;
        mem_wdata = CLEAR_VALUE;
        if (state_q == INIT) begin
            mem_we = 1'b1;
        end else if (prog_we) begin
            mem_we    = 1'b1;
            mem_waddr = prog_addr;
            mem_wdata = prog_data;
        end
    end

    // Storage has no reset; contents come from the sweep and program writes.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        init_done_d  = init_done_q;
        prog_ready_d = prog_ready_q;
        resp_valid_d = resp_valid_q;
        resp_instr_d = resp_instr_q;
        resp_fault_d = resp_fault_q;
        case (state_q)
            INIT: begin
                idx_d = idx_q + 1'b1;
                if (idx_q == IW'(DEPTH - 1)) begin
                    state_d      = RUN;
                    init_done_d  = 1'b1;
                    prog_ready_d = 1'b1;
                end
            end
            RUN: begin
                if (accept) begin
                    resp_valid_d = 1'b1;
                    resp_fault_d = fault_code;
                    resp_instr_d = (fault_code != 2'b00) ? FAULT_INSTR
                                                         : mem[rd_idx];
                end else if (retire) begin
                    resp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= INIT;
            idx_q        <= '0;
            init_done_q  <= 1'b0;
            prog_ready_q <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_instr_q <= '0;
            resp_fault_q <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            init_done_q  <= init_done_d;
            prog_ready_q <= prog_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_instr_q <= resp_instr_d;
            resp_fault_q <= resp_fault_d;
        end
    end

    assign init_done  = init_done_q;
    assign prog_ready = prog_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_instr = resp_instr_q;
    assign resp_fault = resp_fault_q;

endmodule

// File: tb/tb_instr_mem_fetch.sv
module tb_instr_mem_fetch;

    localparam int unsigned DEPTH = 64;
    localparam int unsigned AW    = 32;
    localparam int unsigned IW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          reset_n;
    logic          init_done;
    logic          prog_we;
    logic [IW-1:0] prog_addr;
    logic [31:0]   prog_data;
    logic          prog_ready;
    logic          req_valid;
    logic [AW-1:0] req_addr;
    logic          req_ready;
    logic          resp_valid;
    logic          resp_ready;
    logic [31:0]   resp_instr;
    logic [1:0]    resp_fault;

    int n_assert = 0;
    int n_fail   = 0;

    instr_mem_fetch #(
        .DEPTH      (DEPTH),
        .AW         (AW),
        .CLEAR_VALUE(32'h0000_0000),
        .FAULT_INSTR(32'h0000_0013)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .init_done (init_done),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .prog_ready(prog_ready),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_instr(resp_instr),
        .resp_fault(resp_fault)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: observed simulation still running, expected completion");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_init_done"},  32'(init_done),  32'h0);
        chk({tag, "_prog_ready"}, 32'(prog_ready), 32'h0);
        chk({tag, "_req_ready"},  32'(req_ready),  32'h0);
        chk({tag, "_resp_valid"}, 32'(resp_valid), 32'h0);
        chk({tag, "_resp_instr"}, resp_instr,      32'h0);
        chk({tag, "_resp_fault"}, 32'(resp_fault), 32'h0);
    endtask

    task automatic chk_resp(input string tag, input logic [31:0] instr, input logic [1:0] fault);
        chk({tag, "_valid"}, 32'(resp_valid), 32'h1);
        chk({tag, "_instr"}, resp_instr,      instr);
        chk({tag, "_fault"}, 32'(resp_fault), 32'(fault));
    endtask

    // Counts rising edges until init_done, bounded so a stuck sweep still ends.
    task automatic wait_init(output int n);
        n = 0;
        while (init_done !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
    endtask

    int edges;

    initial begin
        reset_n    = 1'b0;
        prog_we    = 1'b0;
        prog_addr  = '0;
        prog_data  = '0;
        req_valid  = 1'b1;
        req_addr   = 32'h0;
        resp_ready = 1'b1;

        // Reset state with requests offered
        tick(); tick();
        chk_reset_outs("por");

        // Init sweep: exactly DEPTH edges, requests ignored meanwhile
        reset_n = 1'b1;
        for (int i = 0; i < 63; i++) tick();
        chk("init_63_done",  32'(init_done),  32'h0);
        chk("init_63_valid", 32'(resp_valid), 32'h0);
        chk("init_63_rdy",   32'(req_ready),  32'h0);
        tick();
        chk("init_64_done",  32'(init_done),  32'h1);
        chk("init_64_prdy",  32'(prog_ready), 32'h1);
        chk("init_64_rdy",   32'(req_ready),  32'h1);

        // Cleared words at the bottom and top of the array
        tick();
        chk_resp("fetch_0", 32'h0, 2'b00);
        req_addr = 32'hFC;
        tick();
        chk_resp("fetch_fc", 32'h0, 2'b00);
        req_valid = 1'b0;
        tick();
        chk("retire_valid", 32'(resp_valid), 32'h0);

        // Collision plus read-after-write
        prog_we   = 1'b1;
        prog_addr = IW'(1);
        prog_data = 32'h00A0_8193;
        req_valid = 1'b1;
        req_addr  = 32'h4;
        #1;
        chk("coll_rdy", 32'(req_ready), 32'h0);
        tick();
        chk("coll_noacc", 32'(resp_valid), 32'h0);
        prog_we = 1'b0;
        #1;
        chk("coll_rdy_after", 32'(req_ready), 32'h1);
        tick();
        chk_resp("raw_w1", 32'h00A0_8193, 2'b00);

        // Load distinct words 0 and 2 for ordering checks
        req_valid = 1'b0;
        prog_we   = 1'b1;
        prog_addr = IW'(0);
        prog_data = 32'h2222_2222;
        tick();
        prog_addr = IW'(2);
        prog_data = 32'h1111_1111;
        tick();
        prog_we = 1'b0;
        chk("prog_retired", 32'(resp_valid), 32'h0);

        // Backpressure: first response held for three stalled cycles
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        req_addr   = 32'h0;
        tick();
        chk_resp("bp_first", 32'h2222_2222, 2'b00);
        req_addr = 32'h4;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_stall_rdy", 32'(req_ready), 32'h0);
            tick();
            chk_resp("bp_hold", 32'h2222_2222, 2'b00);
        end
        resp_ready = 1'b1;
        #1;
        chk("bp_release_rdy", 32'(req_ready), 32'h1);
        tick();
        chk_resp("bp_second", 32'h00A0_8193, 2'b00);
        req_addr = 32'h8;
        tick();
        chk_resp("bp_third", 32'h1111_1111, 2'b00);

        // Faults, including precedence and no wrap of large addresses
        req_addr = 32'h6;
        tick();
        chk_resp("f_misal", 32'h0000_0013, 2'b01);
        req_addr = 32'h100;
        tick();
        chk_resp("f_oor", 32'h0000_0013, 2'b10);
        req_addr = 32'h102;
        tick();
        chk_resp("f_both", 32'h0000_0013, 2'b01);
        req_addr = 32'hFFFF_FFFC;
        tick();
        chk_resp("f_high", 32'h0000_0013, 2'b10);
        req_valid = 1'b0;
        tick();
        chk("f_retire", 32'(resp_valid), 32'h0);

        // Reset in RUN with a pending response
        req_valid  = 1'b1;
        req_addr   = 32'h4;
        resp_ready = 1'b0;
        tick();
        chk_resp("pre_rst", 32'h00A0_8193, 2'b00);
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset_outs("rst_run");
        resp_ready = 1'b1;
        tick();
        reset_n = 1'b1;
        wait_init(edges);
        chk("run_rst_edges", 32'(edges), 32'd64);

        // Reset during INIT at idx 20
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        chk("mid_init_done", 32'(init_done), 32'h0);
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset_outs("rst_init");
        tick();
        reset_n = 1'b1;
        wait_init(edges);
        chk("init_rst_edges", 32'(edges), 32'd64);

        // Sweep cleared the previously programmed word
        tick();
        chk_resp("post_sweep_w1", 32'h0, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_mem_fetch.md
# instr_mem_fetch

Parametrised instruction memory for the RISC-V core's fetch stage, replacing the fixed 64-word, combinational-read, reset-preloaded instruction ROM. It clears itself after reset with a hardware sweep, accepts program loads through a dedicated write port, and serves fetches over a valid/ready request/response handshake with one-cycle registered latency. Misaligned or out-of-range fetches are flagged and return a safe NOP.

## Interface
- DEPTH, 64: number of instruction words; power of two, ≥2.
- AW, 32: byte-address width of `req_addr`.
- CLEAR_VALUE, 32'h00000000: word written to every location during the init sweep.
- FAULT_INSTR, 32'h00000013: word returned on faulting fetch (`addi x0,x0,0`).
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- init_done  out  1  high once the clear sweep has finished (state RUN).
- prog_we  in  1  program write strobe.
- prog_addr  in  $clog2(DEPTH)  word index of the write.
- prog_data  in  32  instruction word to write.
- prog_ready  out  1  write accepted this cycle when `prog_we && prog_ready`.
- req_valid  in  1  fetch request valid.
- req_addr  in  AW  byte address of the fetch.
- req_ready  out  1  fetch accepted this cycle when `req_valid && req_ready`.
- resp_valid  out  1  response holds valid data.
- resp_ready  in  1  consumer takes the response when `resp_valid && resp_ready`.
- resp_instr  out  32  fetched instruction.
- resp_fault  out  2  00 ok, 01 misaligned (`req_addr[1:0]!=0`), 10 out of range (`req_addr[AW-1:2] >= DEPTH`). Misaligned takes precedence over out of range.

## Operation
- FSM states: INIT and RUN.
- While `reset_n`=0, the block is held in INIT with clear index = 0. On entry to INIT, including an asynchronous reset, outputs are: `init_done`=0, `prog_ready`=0, `req_ready`=0, `resp_valid`=0, `resp_instr`=0, `resp_fault`=0.
- INIT: each clock writes CLEAR_VALUE to word[idx] and increments idx. The write of word DEPTH-1 transitions the FSM to RUN. `prog_we` and `req_valid` are ignored during INIT.
- RUN:
  - `init_done`=1.
  - `prog_ready`=1.
  - `req_ready = !prog_we && (!resp_valid || resp_ready)`.
- Program write: `mem[prog_addr] <= prog_data` at the clock edge. Program writes have priority over fetches, so a fetch is never accepted in the same cycle as a write.
- Fetch accept:
  - Registers the word `mem[req_addr[$clog2(DEPTH)+1:2]]` into `resp_instr`, or FAULT_INSTR on any fault.
  - Registers the fault code into `resp_fault`.
  - Sets `resp_valid`=1.
  - The memory is not accessed on a fault.
- Response hold: while `resp_valid && !resp_ready`, `resp_instr` and `resp_fault` are held stable and no new request is accepted.
- Response retire: `resp_valid && resp_ready` with no new accept in the same cycle → `resp_valid`=0 next cycle. A retire and an accept in the same cycle give back-to-back responses with `resp_valid` staying high.
- Out-of-range check: compares the full word address `req_addr[AW-1:2]` against DEPTH. Addresses never wrap.
- The memory array itself has no reset. Contents are defined only by the init sweep and program writes.

## Timing
- INIT lasts exactly DEPTH rising edges after `reset_n` deasserts. `init_done` rises after edge DEPTH.
- Fetch latency: request accepted at edge N → response visible after edge N with `resp_valid`=1. Throughput is 1 fetch/cycle when `resp_ready`=1.
- Read-after-write: a write at edge N is visible to a fetch accepted at edge N+1 or later.
- Reset asserted mid-INIT or mid-RUN: outputs drop to their reset values immediately. Any pending response is discarded and the sweep restarts from word 0.
- `req_ready` is combinational from `prog_we`, `resp_valid` and `resp_ready`. All other outputs are registered.

## Test plan
- Init sweep: DEPTH=64, release reset, hold `req_valid`=1. Required: `init_done` rises after exactly 64 edges, and fetches of addresses 0x0 and 0xFC then return 32'h00000000 with fault 00.
- Program/fetch: write 32'h00A08193 to word 1 at edge N, request 0x4 at edge N+1. Required: `resp_instr`=32'h00A08193 and `resp_fault`=00 after edge N+1.
- Backpressure: stream requests to 0x0, 0x4, 0x8 with `resp_ready`=0 for 3 cycles. Required: first response held stable and `req_ready`=0 during the stall; then three responses in order, one per cycle.
- Faults: request 0x6, then 0x100 with DEPTH=64. Required: (32'h00000013, 01), then (32'h00000013, 10).
- Collision: `prog_we` and `req_valid` both high in one cycle. Required: `req_ready`=0, the write lands, and the fetch is accepted next cycle returning the new data.
- Reset mid-operation: pull `reset_n` low during INIT idx=20, and separately with `resp_valid`=1 in RUN. Required: outputs reset immediately, and the sweep restarts taking 64 full cycles.
